// File: rtl/bg_pkg.sv
// Shared types and constants for the background-picture fetch stage.
package bg_pkg;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] g;
    logic [7:0] r;
  } bg_pix_t;

  localparam int BG_PIX_STEP = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    FLUSH = 2'd3
  } bg_state_t;

endpackage

// File: rtl/bg_fifo.sv
// Synchronous pixel FIFO; only the pointers are reset, storage is left as-is.
module bg_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 32
) (
  input  logic                     clk_25,
  input  logic                     RESET_L,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  input  logic                     flush,
  output logic [W-1:0]             rdata,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr;
  logic [AW:0]  rptr;
  logic         do_push;
  logic         do_pop;

  assign count   = wptr - rptr;
  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A push into a full FIFO is still accepted when a pop frees the head slot.
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rptr[AW-1:0]];

  always_ff @(posedge clk_25) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk_25 or negedge RESET_L) begin
    if (!RESET_L) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + (AW+1)'(1);
      if (do_pop)  rptr <= rptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/bg_pixel_prefetch.sv
// Background-picture fetch: one SDRAM read in flight, pixel FIFO, one pop per
// active ce_pix, restart at address 0 on every vs rise.
module bg_pixel_prefetch
  import bg_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 24,
  parameter int PIX_STEP   = BG_PIX_STEP
) (
  input  logic                          clk_25,
  input  logic                          RESET_L,
  input  logic                          bg_enable,
  input  logic                          ce_pix,
  input  logic                          hblank,
  input  logic                          vblank,
  input  logic                          vs,
  output logic [ADDR_W-1:0]             sd_addr,
  output logic                          sd_req,
  input  logic                          sd_ack,
  input  logic [31:0]                   sd_dout,
  output logic [7:0]                    bg_r,
  output logic [7:0]                    bg_g,
  output logic [7:0]                    bg_b,
  output logic [7:0]                    bg_a,
  output logic                          underflow,
  output bg_state_t                     dbg_state,
  output logic [$clog2(FIFO_DEPTH):0]   dbg_fifo_count
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  bg_state_t   state_q;
  bg_state_t   state_d;
  logic        vs_d;
  logic        vs_rise;
  logic        active;
  logic        fifo_push;
  logic        fifo_pop;
  logic        fifo_flush;
  logic        fifo_empty;
  logic        fifo_full;
  logic [31:0] fifo_rdata;
  logic [CW-1:0] fifo_count;
  logic        addr_clr;
  logic        addr_inc;
  bg_pix_t     pix_q;

  assign vs_rise    = ce_pix & vs & ~vs_d;
  assign active     = ce_pix & ~hblank & ~vblank;
  assign fifo_pop   = bg_enable & active & ~fifo_empty;
  assign fifo_flush = vs_rise | ~bg_enable;

  bg_fifo #(.DEPTH(FIFO_DEPTH), .W(32)) u_fifo (
    .clk_25  (clk_25),
    .RESET_L (RESET_L),
    .push    (fifo_push),
    .wdata   (sd_dout),
    .pop     (fifo_pop),
    .flush   (fifo_flush),
    .rdata   (fifo_rdata),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (fifo_count)
  );

  always_ff @(posedge clk_25 or negedge RESET_L) begin
    if (!RESET_L) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // sd_req is a one-cycle pulse carrying sd_addr; the single matching sd_ack
  // pulse (with sd_dout) may come any number of cycles later. Only ISSUE may
  // request, and only with a free FIFO slot, so a read never lands on a full FIFO.
  always_comb begin
    state_d   = state_q;
    sd_req    = 1'b0;
    fifo_push = 1'b0;
    addr_clr  = 1'b0;
    addr_inc  = 1'b0;
    case (state_q)
      IDLE: begin
        addr_clr = 1'b1;
        if (bg_enable) state_d = ISSUE;
      end
      ISSUE: begin
        if (!bg_enable) begin
          state_d = IDLE;
        end else if (vs_rise) begin
          addr_clr = 1'b1;
        end else if (!fifo_full) begin
          sd_req  = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (!bg_enable) begin
          state_d = sd_ack ? IDLE : FLUSH;
        end else if (vs_rise) begin
          addr_clr = 1'b1;
          state_d  = sd_ack ? ISSUE : FLUSH;
        end else if (sd_ack) begin
          fifo_push = 1'b1;
          addr_inc  = 1'b1;
          state_d   = ISSUE;
        end
      end
      FLUSH: begin
        // The in-flight read belongs to a discarded picture position; absorb it.
        if (sd_ack) begin
          addr_clr = 1'b1;
          state_d  = bg_enable ? ISSUE : IDLE;
        end else if (vs_rise) begin
          addr_clr = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_25 or negedge RESET_L) begin
    if (!RESET_L) begin
      sd_addr <= '0;
    end else if (addr_clr) begin
      sd_addr <= '0;
    end else if (addr_inc) begin
      sd_addr <= sd_addr + ADDR_W'(PIX_STEP);
    end
  end

  always_ff @(posedge clk_25 or negedge RESET_L) begin
    if (!RESET_L) begin
      vs_d      <= 1'b0;
      pix_q     <= '0;
      underflow <= 1'b0;
    end else begin
      if (ce_pix) vs_d <= vs;
      if (!bg_enable) begin
        pix_q <= '0;
      end else if (active) begin
        pix_q <= fifo_empty ? bg_pix_t'('0) : bg_pix_t'(fifo_rdata);
      end
      if (vs_rise) begin
        underflow <= 1'b0;
      end else if (bg_enable && active && fifo_empty) begin
        underflow <= 1'b1;
      end
    end
  end

  assign bg_a           = pix_q.a;
  assign bg_b           = pix_q.b;
  assign bg_g           = pix_q.g;
  assign bg_r           = pix_q.r;
  assign dbg_state      = state_q;
  assign dbg_fifo_count = fifo_count;

endmodule

// File: tb/tb_bg_pixel_prefetch.sv
// Bench for bg_pixel_prefetch: SDRAM responder, pixel scoreboard, and a
// direct check of the FIFO's simultaneous push/pop corners.
module tb_bg_pixel_prefetch;
  import bg_pkg::*;

  logic        clk_25 = 1'b0;
  logic        RESET_L = 1'b0;
  logic        bg_enable = 1'b0;
  logic        ce_pix = 1'b0;
  logic        hblank = 1'b0;
  logic        vblank = 1'b1;
  logic        vs = 1'b0;
  logic [23:0] sd_addr;
  logic        sd_req;
  logic        sd_ack = 1'b0;
  logic [31:0] sd_dout = '0;
  logic [7:0]  bg_r, bg_g, bg_b, bg_a;
  logic        underflow;
  bg_state_t   dbg_state;
  logic [3:0]  dbg_fifo_count;

  logic        f_push = 1'b0;
  logic        f_pop = 1'b0;
  logic        f_flush = 1'b0;
  logic [31:0] f_wdata = '0;
  logic [31:0] f_rdata;
  logic        f_empty, f_full;
  logic [3:0]  f_count;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int ack_lat = 3;
  int req_cnt = 0;
  int flush_edge = 0;
  int prev_r = -1;
  logic [23:0] prev_addr = '0;
  int viol_state = 0;
  int viol_full = 0;
  logic [31:0] exp_q[$];
  logic [31:0] f_q[$];

  bg_pixel_prefetch #(.FIFO_DEPTH(8), .ADDR_W(24), .PIX_STEP(2)) dut (
    .clk_25         (clk_25),
    .RESET_L        (RESET_L),
    .bg_enable      (bg_enable),
    .ce_pix         (ce_pix),
    .hblank         (hblank),
    .vblank         (vblank),
    .vs             (vs),
    .sd_addr        (sd_addr),
    .sd_req         (sd_req),
    .sd_ack         (sd_ack),
    .sd_dout        (sd_dout),
    .bg_r           (bg_r),
    .bg_g           (bg_g),
    .bg_b           (bg_b),
    .bg_a           (bg_a),
    .underflow      (underflow),
    .dbg_state      (dbg_state),
    .dbg_fifo_count (dbg_fifo_count)
  );

  bg_fifo #(.DEPTH(8), .W(32)) u_fifo (
    .clk_25  (clk_25),
    .RESET_L (RESET_L),
    .push    (f_push),
    .wdata   (f_wdata),
    .pop     (f_pop),
    .flush   (f_flush),
    .rdata   (f_rdata),
    .empty   (f_empty),
    .full    (f_full),
    .count   (f_count)
  );

  // clock / cycle counter
  always #20 clk_25 = ~clk_25;
  initial forever begin
    @(posedge clk_25);
    cyc++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk_25);
    #1;
  endtask

  // SDRAM responder: data = address; keeps data only for reads issued after the last flush
  initial forever begin
    @(negedge clk_25);
    if (sd_req) begin
      int r;
      logic [23:0] a;
      logic [23:0] ea;
      r  = cyc + 1;
      a  = sd_addr;
      ea = (prev_r < flush_edge) ? 24'd0 : prev_addr + 24'd2;
      chk("req_addr", 32'(a), 32'(ea));
      prev_r    = r;
      prev_addr = a;
      req_cnt++;
      repeat (ack_lat) @(posedge clk_25);
      #1;
      sd_ack  = 1'b1;
      sd_dout = {8'h00, a};
      @(posedge clk_25);
      #1;
      sd_ack = 1'b0;
      #2;
      if (r > flush_edge) exp_q.push_back({8'h00, a});
    end
  end

  initial forever begin
    @(negedge clk_25);
    if (sd_req && dbg_state != ISSUE) viol_state++;
    if (sd_req && dbg_fifo_count == 4'd8) viol_full++;
  end

  task automatic pix(input bit act);
    logic [31:0] e;
    ce_pix = 1'b1;
    hblank = ~act;
    tick();
    ce_pix = 1'b0;
    if (act) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'd0;
      chk("pix", {bg_a, bg_b, bg_g, bg_r}, e);
    end
    tick();
  endtask

  task automatic vs_pulse();
    vblank     = 1'b1;
    hblank     = 1'b0;
    vs         = 1'b1;
    ce_pix     = 1'b1;
    flush_edge = cyc + 1;
    exp_q.delete();
    tick();
    ce_pix = 1'b0;
    tick();
    vs     = 1'b0;
    ce_pix = 1'b1;
    tick();
    ce_pix = 1'b0;
    tick();
  endtask

  task automatic wait_req(input int lim);
    int  start;
    bit  got;
    start = req_cnt;
    got   = 1'b0;
    for (int i = 0; i < lim; i++) begin
      if (req_cnt != start) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    chk("wait_req", 32'(got), 32'd1);
  endtask

  task automatic f_op(input bit pu, input bit po, input logic [31:0] d);
    int n;
    logic [31:0] tmp;
    f_push  = pu;
    f_pop   = po;
    f_wdata = d;
    #1;
    n = f_q.size();
    if (po && n > 0) chk("fifo_head", f_rdata, f_q[0]);
    tick();
    f_push = 1'b0;
    f_pop  = 1'b0;
    if (po && n > 0) tmp = f_q.pop_front();
    if (pu && (n < 8 || (po && n > 0))) f_q.push_back(d);
    chk("fifo_count", 32'(f_count), 32'(f_q.size()));
  endtask

  task automatic report();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
  endtask

  initial begin
    #400000;
    n_bad++;
    $display("FAIL watchdog: time %0t reached, expected finish earlier", $time);
    report();
    $finish;
  end

  initial begin
    int n;
    repeat (2) @(negedge clk_25);
    chk("rst_req", 32'(sd_req), 32'd0);
    chk("rst_addr", 32'(sd_addr), 32'd0);
    chk("rst_pix", {bg_a, bg_b, bg_g, bg_r}, 32'd0);
    chk("rst_uf", 32'(underflow), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    chk("rst_count", 32'(dbg_fifo_count), 32'd0);
    chk("rst_fifo_count", 32'(f_count), 32'd0);
    @(posedge clk_25);
    #1;
    RESET_L = 1'b1;
    tick();

    // FIFO push+pop at count 4, 8 and 0
    for (int i = 0; i < 4; i++) f_op(1'b1, 1'b0, 32'h100 + i);
    f_op(1'b1, 1'b1, 32'h200);
    for (int i = 0; i < 4; i++) f_op(1'b1, 1'b0, 32'h300 + i);
    f_op(1'b1, 1'b1, 32'h400);
    for (int i = 0; i < 8; i++) f_op(1'b0, 1'b1, 32'h0);
    f_op(1'b1, 1'b1, 32'h500);
    f_op(1'b0, 1'b1, 32'h0);

    // fill: 8 reads 0..14, then stall on full
    bg_enable = 1'b1;
    hblank    = 1'b0;
    vblank    = 1'b1;
    repeat (80) tick();
    chk("fill_reqs", 32'(req_cnt), 32'd8);
    chk("fill_count", 32'(dbg_fifo_count), 32'd8);

    // steady pixel stream, lines of 8 with refill in hblank
    vblank = 1'b0;
    for (int l = 0; l < 4; l++) begin
      for (int p = 0; p < 8; p++) pix(1'b1);
      for (int p = 0; p < 20; p++) pix(1'b0);
    end
    chk("stream_uf", 32'(underflow), 32'd0);

    // vs rise with a read outstanding
    for (int p = 0; p < 8; p++) pix(1'b1);
    vblank = 1'b1;
    hblank = 1'b0;
    wait_req(30);
    vs_pulse();
    chk("vs_uf", 32'(underflow), 32'd0);
    repeat (60) tick();
    vblank = 1'b0;
    for (int p = 0; p < 8; p++) pix(1'b1);
    for (int p = 0; p < 20; p++) pix(1'b0);

    // slow SDRAM: starvation
    ack_lat = 40;
    for (int p = 0; p < 24; p++) pix(1'b1);
    chk("slow_uf_set", 32'(underflow), 32'd1);
    ack_lat = 3;
    vs_pulse();
    chk("slow_uf_clr", 32'(underflow), 32'd0);
    repeat (80) tick();

    // bg_enable dropped in WAIT
    vblank = 1'b0;
    pix(1'b1);
    pix(1'b1);
    vblank = 1'b1;
    hblank = 1'b0;
    wait_req(40);
    bg_enable  = 1'b0;
    flush_edge = cyc + 1;
    exp_q.delete();
    tick();
    chk("dis_state_flush", 32'(dbg_state), 32'(FLUSH));
    chk("dis_pix", {bg_a, bg_b, bg_g, bg_r}, 32'd0);
    chk("dis_count", 32'(dbg_fifo_count), 32'd0);
    repeat (8) tick();
    chk("dis_state_idle", 32'(dbg_state), 32'(IDLE));
    n = req_cnt;
    repeat (30) tick();
    chk("dis_no_req", 32'(req_cnt), 32'(n));

    // reset asserted mid-read
    bg_enable = 1'b1;
    repeat (60) tick();
    vblank = 1'b0;
    pix(1'b1);
    pix(1'b1);
    vblank = 1'b1;
    hblank = 1'b0;
    wait_req(20);
    #10;
    RESET_L = 1'b0;
    #1;
    chk("arst_addr", 32'(sd_addr), 32'd0);
    chk("arst_req", 32'(sd_req), 32'd0);
    chk("arst_pix", {bg_a, bg_b, bg_g, bg_r}, 32'd0);
    chk("arst_uf", 32'(underflow), 32'd0);
    chk("arst_state", 32'(dbg_state), 32'(IDLE));
    chk("arst_count", 32'(dbg_fifo_count), 32'd0);
    flush_edge = cyc + 1;
    exp_q.delete();
    bg_enable = 1'b0;
    n = req_cnt;
    tick();
    RESET_L = 1'b1;
    repeat (8) tick();
    chk("late_ack_state", 32'(dbg_state), 32'(IDLE));
    chk("late_ack_count", 32'(dbg_fifo_count), 32'd0);
    chk("late_ack_no_req", 32'(req_cnt), 32'(n));

    chk("req_outside_issue", 32'(viol_state), 32'd0);
    chk("req_while_full", 32'(viol_full), 32'd0);
    report();
    $finish;
  end

endmodule
